// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and status signals of alu_arbiter, grouped for the
// slave (arbiter) and master (requesters plus ALU environment) sides.
interface alu_arbiter_if;
    localparam int unsigned DW = 4;

    logic          req0, req1;
    logic [DW-1:0] a0, b0, f0, a1, b1, f1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] y0, y1;
    logic          c0, c1;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic [DW-1:0] alu_y;
    logic          alu_c;
    logic          busy;

    modport slave (
        input  req0, req1, a0, b0, f0, a1, b1, f1, alu_y, alu_c,
        output gnt0, gnt1, done0, done1, y0, y1, c0, c1,
               alu_a, alu_b, alu_f, busy
    );

    modport master (
        output req0, req1, a0, b0, f0, a1, b1, f1, alu_y, alu_c,
        input  gnt0, gnt1, done0, done1, y0, y1, c0, c1,
               alu_a, alu_b, alu_f, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter for one shared ALU with a fixed result
// latency; operands are held on the ALU drive until the result is captured.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] y0_q, y0_d, y1_q, y1_d;
    logic          c0_q, c0_d, c1_q, c1_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_f_q, alu_f_d;
    logic          pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            y0_q    <= '0;
            y1_q    <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_f_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            alu_f_q <= alu_f_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        y0_d    = y0_q;
        y1_d    = y1_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        alu_f_d = alu_f_q;
        pick    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // on a tie the requester not served last wins
                    pick    = (bus.req0 && bus.req1) ? !owner_q : bus.req1;
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = EXEC;
                    gnt0_d  = !pick;
                    gnt1_d  = pick;
                    alu_a_d = pick ? bus.a1 : bus.a0;
                    alu_b_d = pick ? bus.b1 : bus.b0;
                    alu_f_d = pick ? bus.f1 : bus.f0;
                end
            end
            EXEC: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    state_d = DONE;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    if (owner_q) begin
                        y1_d = bus.alu_y;
                        c1_d = bus.alu_c;
                    end else begin
                        y0_d = bus.alu_y;
                        c0_d = bus.alu_c;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.busy  = busy_q;
    assign bus.y0    = y0_q;
    assign bus.y1    = y1_q;
    assign bus.c0    = c0_q;
    assign bus.c1    = c1_q;
    assign bus.alu_a = alu_a_q;
    assign bus.alu_b = alu_b_q;
    assign bus.alu_f = alu_f_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: cycle table at ALU_LAT=1, hand sequences for latency
// and reset corners, and random traffic against a transaction-level model.
module tb_alu_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic       ovr_en = 1'b0;
    logic [4:0] ovr    = 5'h00;

    always #5 clk = ~clk;

    alu_arbiter_if ifa ();
    alu_arbiter_if ifb ();

    alu_arbiter #(.ALU_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    alu_arbiter #(.ALU_LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // reference ALU: odd function code adds, even subtracts; bit 4 is the flag
    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] f);
        return f[0] ? (5'(a) + 5'(b)) : (5'(a) - 5'(b));
    endfunction

    assign {ifa.alu_c, ifa.alu_y} = alu_fn(ifa.alu_a, ifa.alu_b, ifa.alu_f);
    assign {ifb.alu_c, ifb.alu_y} = ovr_en ? ovr : alu_fn(ifb.alu_a, ifb.alu_b, ifb.alu_f);

    typedef struct packed {
        logic g0, g1, d0, d1, bz;
        logic c0; logic [3:0] y0;
        logic c1; logic [3:0] y1;
        logic [11:0] alu;
    } obs_t;

    typedef struct packed {
        logic [1:0]  req;   // {req0, req1}
        logic [11:0] op0;   // {a0, b0, f0}
        logic [11:0] op1;   // {a1, b1, f1}
        logic [4:0]  pul;   // {gnt0, gnt1, done0, done1, busy}
        logic [4:0]  r0;    // {c0, y0}
        logic [4:0]  r1;    // {c1, y1}
    } vec_t;

    function automatic obs_t get_obs(input bit s);
        obs_t o;
        o.g0 = s ? ifb.gnt0  : ifa.gnt0;   o.g1 = s ? ifb.gnt1  : ifa.gnt1;
        o.d0 = s ? ifb.done0 : ifa.done0;  o.d1 = s ? ifb.done1 : ifa.done1;
        o.bz = s ? ifb.busy  : ifa.busy;
        o.c0 = s ? ifb.c0 : ifa.c0;        o.y0 = s ? ifb.y0 : ifa.y0;
        o.c1 = s ? ifb.c1 : ifa.c1;        o.y1 = s ? ifb.y1 : ifa.y1;
        o.alu = s ? {ifb.alu_a, ifb.alu_b, ifb.alu_f} : {ifa.alu_a, ifa.alu_b, ifa.alu_f};
        return o;
    endfunction

    task automatic drive(input bit s, input logic [1:0] rq, input logic [11:0] op0,
                         input logic [11:0] op1);
        ifa.req0 = !s & rq[1];  ifa.req1 = !s & rq[0];
        ifb.req0 =  s & rq[1];  ifb.req1 =  s & rq[0];
        {ifa.a0, ifa.b0, ifa.f0} = op0;  {ifa.a1, ifa.b1, ifa.f1} = op1;
        {ifb.a0, ifb.b0, ifb.f0} = op0;  {ifb.a1, ifb.b1, ifb.f1} = op1;
    endtask

    task automatic chk(input string nm, input int cyc, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] pul(input obs_t o);
        return 16'({o.g0, o.g1, o.d0, o.d1, o.bz});
    endfunction

    function automatic logic [15:0] res(input obs_t o);
        return 16'({o.c0, o.y0, o.c1, o.y1});
    endfunction

    task automatic do_reset();
        drive(1'b0, 2'b00, 12'h000, 12'h000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Transaction-level model: a request seen while the arbiter is free is
    // scheduled as gnt at +1, done at +1+L, and the arbiter is free again at +L+2.
    task automatic run_random(input bit s, input int n);
        int L = s ? 3 : 1;
        int gnt_c = -1, done_c = -1, next_free = 0;
        bit win = 1'b0, last = 1'b1;
        logic [4:0]  rsl = 5'h00;
        logic [11:0] lat = 12'h000;
        logic [4:0]  ey[2];
        logic        r[2];
        logic [11:0] op[2];
        logic        eb;
        obs_t o;
        ey[0] = 5'h00; ey[1] = 5'h00; r[0] = 1'b0; r[1] = 1'b0;
        op[0] = 12'h000; op[1] = 12'h000;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            o = get_obs(s);
            if (k == done_c) ey[win] = rsl;
            eb = (k >= gnt_c) && (k <= done_c);
            chk("rnd pulses", k, pul(o), 16'({k == gnt_c && !win, k == gnt_c && win,
                                               k == done_c && !win, k == done_c && win, eb}));
            chk("rnd results", k, res(o), 16'({ey[0], ey[1]}));
            if (eb) chk("rnd alu drive", k, 16'(o.alu), 16'(lat));
            for (int i = 0; i < 2; i++) begin
                if (k == gnt_c && int'(win) == i) r[i] = 1'b0;
                else if (r[i]) begin
                    if ($urandom_range(7) == 0) r[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    r[i]  = 1'b1;
                    op[i] = 12'($urandom);
                end
            end
            drive(s, {r[0], r[1]}, op[0], op[1]);
            if (k >= next_free && (r[0] || r[1])) begin
                win       = (r[0] && r[1]) ? !last : r[1];
                last      = win;
                gnt_c     = k + 1;
                done_c    = k + 1 + L;
                next_free = k + L + 2;
                lat       = op[win];
                rsl       = alu_fn(lat[11:8], lat[7:4], lat[3:0]);
            end
        end
        drive(s, 2'b00, 12'h000, 12'h000);
    endtask

    vec_t tbl[23];
    obs_t o;

    initial begin
        tbl[0]  = {2'b11, 12'h211, 12'h730, 5'b00000, 5'h00, 5'h00};
        tbl[1]  = {2'b01, 12'h211, 12'h730, 5'b10001, 5'h00, 5'h00};
        tbl[2]  = {2'b01, 12'h211, 12'h730, 5'b00101, 5'h03, 5'h00};
        tbl[3]  = {2'b01, 12'h211, 12'h730, 5'b00000, 5'h03, 5'h00};
        tbl[4]  = {2'b00, 12'h211, 12'h730, 5'b01001, 5'h03, 5'h00};
        tbl[5]  = {2'b00, 12'h211, 12'h730, 5'b00011, 5'h03, 5'h04};
        tbl[6]  = {2'b11, 12'h981, 12'h391, 5'b00000, 5'h03, 5'h04};
        tbl[7]  = {2'b11, 12'h981, 12'h391, 5'b10001, 5'h03, 5'h04};
        tbl[8]  = {2'b11, 12'h981, 12'h391, 5'b00101, 5'h11, 5'h04};
        tbl[9]  = {2'b11, 12'h981, 12'h391, 5'b00000, 5'h11, 5'h04};
        tbl[10] = {2'b11, 12'h981, 12'h391, 5'b01001, 5'h11, 5'h04};
        tbl[11] = {2'b11, 12'h981, 12'h391, 5'b00011, 5'h11, 5'h0C};
        tbl[12] = {2'b11, 12'h981, 12'h391, 5'b00000, 5'h11, 5'h0C};
        tbl[13] = {2'b11, 12'h981, 12'h391, 5'b10001, 5'h11, 5'h0C};
        tbl[14] = {2'b11, 12'h981, 12'h391, 5'b00101, 5'h11, 5'h0C};
        tbl[15] = {2'b11, 12'h981, 12'h391, 5'b00000, 5'h11, 5'h0C};
        tbl[16] = {2'b00, 12'h981, 12'h391, 5'b01001, 5'h11, 5'h0C};
        tbl[17] = {2'b00, 12'h981, 12'h391, 5'b00011, 5'h11, 5'h0C};
        tbl[18] = {2'b01, 12'h981, 12'h111, 5'b00000, 5'h11, 5'h0C};
        tbl[19] = {2'b10, 12'h621, 12'h111, 5'b01001, 5'h11, 5'h0C};
        tbl[20] = {2'b00, 12'h621, 12'h111, 5'b00011, 5'h11, 5'h02};
        tbl[21] = {2'b00, 12'h621, 12'h111, 5'b00000, 5'h11, 5'h02};
        tbl[22] = {2'b00, 12'h621, 12'h111, 5'b00000, 5'h11, 5'h02};

        // reset values with no clock edge
        drive(1'b0, 2'b00, 12'h000, 12'h000);
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            o = get_obs(s[0]);
            chk("reset pulses", 0, pul(o), 16'h0000);
            chk("reset results", 0, res(o), 16'h0000);
            chk("reset alu drive", 0, 16'(o.alu), 16'h0000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU_LAT=1: tie from reset, round-robin, request withdrawn while busy
        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            o = get_obs(1'b0);
            chk("tbl pulses", i, pul(o), 16'(tbl[i].pul));
            chk("tbl results", i, res(o), 16'({tbl[i].r0, tbl[i].r1}));
            drive(1'b0, tbl[i].req, tbl[i].op0, tbl[i].op1);
        end

        // ALU_LAT=3: result presented only in the last EXEC cycle
        do_reset();
        ovr_en = 1'b1; ovr = 5'h00;
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 12'h000, 12'hF05);
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("lat3 c1 pulses", 1, pul(o), 16'b01001);
        drive(1'b1, 2'b00, 12'h000, 12'h000);
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("lat3 c2 pulses", 2, pul(o), 16'b00001);
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("lat3 c3 pulses", 3, pul(o), 16'b00001);
        ovr = 5'h1A;
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("lat3 c4 pulses", 4, pul(o), 16'b00011);
        chk("lat3 c4 results", 4, res(o), 16'h001A);
        chk("lat3 c4 alu drive", 4, 16'(o.alu), 16'h0F05);
        ovr = 5'h00;
        @(posedge clk); #1;
        o = get_obs(1'b1);
        chk("lat3 c5 pulses", 5, pul(o), 16'b00000);
        chk("lat3 c5 results", 5, res(o), 16'h001A);
        ovr_en = 1'b0;

        // reset asserted in the grant cycle aborts the transaction
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 12'h561, 12'h000);
        @(posedge clk); #1;
        o = get_obs(1'b0);
        chk("abort gnt", 1, pul(o), 16'b10001);
        chk("abort alu drive", 1, 16'(o.alu), 16'h0561);
        drive(1'b0, 2'b00, 12'h000, 12'h000);
        rst_n = 1'b0;
        #1;
        o = get_obs(1'b0);
        chk("abort immediate pulses", 1, pul(o), 16'h0000);
        chk("abort immediate alu", 1, 16'(o.alu), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            o = get_obs(1'b0);
            chk("abort no done", i, pul(o), 16'h0000);
            chk("abort no capture", i, res(o), 16'h0000);
        end
        drive(1'b0, 2'b10, 12'h121, 12'h000);
        @(posedge clk); #1;
        o = get_obs(1'b0);
        chk("after abort gnt", 1, pul(o), 16'b10001);
        drive(1'b0, 2'b00, 12'h000, 12'h000);
        @(posedge clk); #1;
        o = get_obs(1'b0);
        chk("after abort done", 2, pul(o), 16'b00101);
        chk("after abort result", 2, res(o), 16'h0060);

        // random traffic on both latencies
        do_reset();
        run_random(1'b0, 1500);
        do_reset();
        run_random(1'b1, 1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, giving the ALU result latency in clk cycles; legal range is 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: level request from requester 0 and requester 1.
REQ-005 SHALL have ports a0, b0, f0, a1, b1, f1, input, 4 bits each: operands and function code of each requester.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle grant pulse; the operands were latched.
REQ-007 SHALL have ports done0 and done1, output, 1 bit each: one-cycle completion pulse.
REQ-008 SHALL have ports y0 and y1, output, 4 bits each: the captured ALU result per requester.
REQ-009 SHALL have ports c0 and c1, output, 1 bit each: the captured ALU carry/flag per requester.
REQ-010 SHALL have ports alu_a, alu_b, alu_f, output, 4 bits each: registered drive to the shared ALU.
REQ-011 SHALL have ports alu_y (input, 4 bits) and alu_c (input, 1 bit): the shared ALU result and flag.
REQ-012 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-013 SHALL implement an FSM with the states IDLE, EXEC and DONE, plus a 4-bit latency counter and a 1-bit owner register.
REQ-014 SHALL, in IDLE with exactly one reqN high at a rising edge, latch aN/bN/fN into alu_a/alu_b/alu_f, set owner=N and enter EXEC.
REQ-015 SHALL, in IDLE with both requests high, grant the requester other than the one last served (round-robin by owner).
REQ-016 SHALL assert gntN, where N is the new owner, for exactly the first EXEC cycle.
REQ-017 SHALL hold alu_a/alu_b/alu_f stable from the grant edge through the DONE state.
REQ-018 SHALL, in EXEC, count ALU_LAT cycles; on the edge ending the last EXEC cycle, load alu_y into y(owner) and alu_c into c(owner), then enter DONE.
REQ-019 SHALL assert done(owner) for exactly the single DONE cycle, then go unconditionally to IDLE.
REQ-020 SHALL give, for a req first high in cycle 0 with the FSM idle: gnt in cycle 1, done in cycle ALU_LAT+1, and IDLE in cycle ALU_LAT+2.
REQ-021 SHALL give a minimum issue-to-issue spacing of ALU_LAT+2 cycles.
REQ-022 SHALL ignore requests outside IDLE; they are sampled only in IDLE.
REQ-023 SHALL treat a req that is still high in IDLE after its own done as a new request; requesters deassert req on gnt.
REQ-024 SHALL leave y(non-owner) and c(non-owner) unchanged by any transaction.
REQ-025 SHALL never assert gnt0 and gnt1 together, nor done0 and done1 together.
REQ-026 SHALL not grant a request that is withdrawn before being sampled in IDLE, and SHALL produce no pulses for it.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, counter 0 and owner=1 (so req0 wins the first tie).
REQ-028 SHALL, while rst_n is low, force busy=0, all gnt/done=0, y0/y1=0, c0/c1=0 and alu_a/alu_b/alu_f=0, with no clock required.
REQ-029 SHALL, on a reset asserted mid-transaction, abort it: no done pulse and no capture, with outputs at their reset values immediately.
REQ-030 SHALL, after rst_n rises, act on a request at the first rising edge at which it is high.

Verification
REQ-031 SHALL cover single request, ALU_LAT=1: req0 with a0=2, b0=1, f0=1 in cycle 0, and alu_y=3 -> gnt0 in cycle 1, done0 in cycle 2 with y0=3, busy high in cycles 1-2.
REQ-032 SHALL cover a tie from reset: req0 and req1 both high -> requester 0 served first, requester 1 granted in the first IDLE after done0, with no overlapping pulses.
REQ-033 SHALL cover round-robin: both requests held high for 4 transactions -> grant order 0,1,0,1 with spacing ALU_LAT+2.
REQ-034 SHALL cover ALU_LAT=3: req1 with a1=15, b1=0, f1=5, and alu_y=4'hA, alu_c=1 presented in the last EXEC cycle -> done1 in cycle 4, y1=4'hA, c1=1, y0/c0 unchanged.
REQ-035 SHALL cover reset in EXEC: rst_n pulled low in cycle 1 of a transaction -> busy=0 and alu_a=0 immediately, no done pulse, and the next request is handled normally.
